// File: rtl/wash_program_timer.sv
// wash_program_timer: sequencing datapath for the washer state controller.
// Generates the begin/finish countdowns, the active wash phase code, the
// program-done flag and the total remaining seconds for display.
// Optional build macro: WPT_TICK_DIV_EN - derive the seconds tick internally
// from cp (TICK_DIV cycles per tick) and ignore the tick port.
module wash_program_timer #(
    parameter int unsigned INIT_SEC   = 3,
    parameter int unsigned FINISH_SEC = 5,
    parameter int unsigned WASH_SEC   = 20,
    parameter int unsigned SPIN1_SEC  = 8,
    parameter int unsigned RINSE_SEC  = 12,
    parameter int unsigned SPIN2_SEC  = 10,
    parameter int unsigned TICK_DIV   = 50
) (
    input  logic       cp,
    input  logic       rst,
    input  logic       tick,
    input  logic [2:0] state,
    input  logic [1:0] modeSel,
    output logic [2:0] initTime,
    output logic [2:0] shinning,
    output logic       hadFinish,
    output logic [2:0] finishTime,
    output logic [7:0] remainSec
);

    typedef enum logic [2:0] {
        ST_SHUTDOWN = 3'd0,
        ST_BEGIN    = 3'd1,
        ST_SET      = 3'd2,
        ST_RUN      = 3'd3,
        ST_ERROR    = 3'd4,
        ST_PAUSE    = 3'd5,
        ST_FINISH   = 3'd6,
        ST_ILLEGAL  = 3'd7
    } ctrl_state_t;

    ctrl_state_t ctrl_st;
    assign ctrl_st = ctrl_state_t'(state);

    // Enabled phases per mode, bit order {7,5,3,1}
    function automatic logic [3:0] phase_mask(input logic [1:0] m);
        logic [3:0] mask;
        case (m)
            2'd0:    mask = 4'b1111;
            2'd1:    mask = 4'b1001;
            2'd2:    mask = 4'b1100;
            default: mask = 4'b1000;
        endcase
        return mask;
    endfunction

    function automatic logic [5:0] phase_len(input logic [2:0] code);
        logic [5:0] len;
        case (code)
            3'd1:    len = 6'(WASH_SEC);
            3'd3:    len = 6'(SPIN1_SEC);
            3'd5:    len = 6'(RINSE_SEC);
            3'd7:    len = 6'(SPIN2_SEC);
            default: len = '0;
        endcase
        return len;
    endfunction

    function automatic logic [2:0] first_phase(input logic [1:0] m);
        logic [3:0] mask;
        logic [2:0] code;
        mask = phase_mask(m);
        if (mask[0])      code = 3'd1;
        else if (mask[1]) code = 3'd3;
        else if (mask[2]) code = 3'd5;
        else if (mask[3]) code = 3'd7;
        else              code = 3'd0;
        return code;
    endfunction

    // Next enabled phase strictly after cur; 0 when cur is the last one
    function automatic logic [2:0] next_phase(input logic [1:0] m, input logic [2:0] cur);
        logic [3:0] mask;
        logic [2:0] code;
        mask = phase_mask(m);
        if (cur < 3'd3 && mask[1])      code = 3'd3;
        else if (cur < 3'd5 && mask[2]) code = 3'd5;
        else if (cur < 3'd7 && mask[3]) code = 3'd7;
        else                            code = 3'd0;
        return code;
    endfunction

    function automatic logic [7:0] program_sum(input logic [1:0] m);
        logic [3:0] mask;
        logic [7:0] sum;
        mask = phase_mask(m);
        sum  = '0;
        if (mask[0]) sum = sum + 8'(WASH_SEC);
        if (mask[1]) sum = sum + 8'(SPIN1_SEC);
        if (mask[2]) sum = sum + 8'(RINSE_SEC);
        if (mask[3]) sum = sum + 8'(SPIN2_SEC);
        return sum;
    endfunction

    logic tick_w;

`ifdef WPT_TICK_DIV_EN
    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic             unused_tick;

    assign unused_tick = tick;

    // Internal seconds strobe on the last count of each divider period
    always_comb begin
        tick_w = (div_q == DIV_W'(TICK_DIV - 1));
        div_d  = tick_w ? '0 : div_q + 1'b1;
    end

    // Divider counter register
    always_ff @(posedge cp) begin
        if (rst) div_q <= '0;
        else     div_q <= div_d;
    end
`else
    logic unused_div;

    assign unused_div = (TICK_DIV == 0);
    assign tick_w     = tick;
`endif

    logic [2:0] init_q, init_d;
    logic [2:0] shin_q, shin_d;
    logic       hf_q, hf_d;
    logic [2:0] fin_q, fin_d;
    logic [7:0] rem_q, rem_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] mode_q, mode_d;

    // Next-state: actions keyed on the controller state sampled this cycle
    always_comb begin
        init_d = init_q;
        shin_d = shin_q;
        hf_d   = hf_q;
        fin_d  = fin_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        case (ctrl_st)
            ST_SHUTDOWN: begin
                init_d = 3'(INIT_SEC);
                fin_d  = 3'(FINISH_SEC);
                shin_d = '0;
                hf_d   = 1'b0;
                rem_d  = '0;
                cnt_d  = '0;
                mode_d = '0;
            end
            ST_BEGIN: begin
                if (tick_w && init_q != 3'd0) init_d = init_q - 3'd1;
                fin_d  = 3'(FINISH_SEC);
                shin_d = '0;
                hf_d   = 1'b0;
                rem_d  = '0;
                cnt_d  = '0;
                mode_d = '0;
            end
            ST_SET: begin
                mode_d = modeSel;
                hf_d   = 1'b0;
                fin_d  = 3'(FINISH_SEC);
                init_d = '0;
                shin_d = first_phase(modeSel);
                cnt_d  = phase_len(first_phase(modeSel));
                rem_d  = program_sum(modeSel);
            end
            ST_RUN: begin
                if (tick_w && !hf_q) begin
                    if (rem_q != 8'd0) rem_d = rem_q - 8'd1;
                    if (cnt_q > 6'd1) begin
                        cnt_d = cnt_q - 6'd1;
                    end else if (cnt_q == 6'd1) begin
                        if (next_phase(mode_q, shin_q) != 3'd0) begin
                            shin_d = next_phase(mode_q, shin_q);
                            cnt_d  = phase_len(next_phase(mode_q, shin_q));
                        end else begin
                            shin_d = '0;
                            cnt_d  = '0;
                            rem_d  = '0;
                            hf_d   = 1'b1;
                        end
                    end
                end
            end
            ST_FINISH: begin
                hf_d = 1'b1;
                if (tick_w && fin_q != 3'd0) fin_d = fin_q - 3'd1;
            end
            default: ;  // error, pause, illegal: hold everything
        endcase
    end

    // State registers; reset takes priority over tick and state
    always_ff @(posedge cp) begin
        if (rst) begin
            init_q <= 3'(INIT_SEC);
            fin_q  <= 3'(FINISH_SEC);
            shin_q <= '0;
            hf_q   <= 1'b0;
            rem_q  <= '0;
            cnt_q  <= '0;
            mode_q <= '0;
        end else begin
            init_q <= init_d;
            fin_q  <= fin_d;
            shin_q <= shin_d;
            hf_q   <= hf_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    assign initTime   = init_q;
    assign shinning   = shin_q;
    assign hadFinish  = hf_q;
    assign finishTime = fin_q;
    assign remainSec  = rem_q;

endmodule

// File: tb/tb_wash_program_timer.sv
// Directed table-driven bench for wash_program_timer
// (INIT 3, FINISH 5, WASH 4, SPIN1 2, RINSE 3, SPIN2 2).
module tb_wash_program_timer;

    logic       cp = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic [2:0] state = 3'd0;
    logic [1:0] modeSel = 2'd0;
    logic [2:0] initTime;
    logic [2:0] shinning;
    logic       hadFinish;
    logic [2:0] finishTime;
    logic [7:0] remainSec;

    int checks = 0;
    int errors = 0;

    wash_program_timer #(
        .INIT_SEC(3), .FINISH_SEC(5), .WASH_SEC(4), .SPIN1_SEC(2),
        .RINSE_SEC(3), .SPIN2_SEC(2), .TICK_DIV(4)
    ) dut (
        .cp(cp), .rst(rst), .tick(tick), .state(state), .modeSel(modeSel),
        .initTime(initTime), .shinning(shinning), .hadFinish(hadFinish),
        .finishTime(finishTime), .remainSec(remainSec)
    );

    always #5 cp = ~cp;

    typedef struct {
        string      name;
        logic       rst;
        logic [2:0] st;
        logic [1:0] m;
        logic       tk;
        logic [2:0] e_init;
        logic [2:0] e_shin;
        logic       e_hf;
        logic [2:0] e_fin;
        logic [7:0] e_rem;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic r, logic [2:0] s, logic [1:0] m, logic t,
                                logic [2:0] ei, logic [2:0] es, logic eh, logic [2:0] ef,
                                logic [7:0] er);
        vec_t v;
        v.name = n; v.rst = r; v.st = s; v.m = m; v.tk = t;
        v.e_init = ei; v.e_shin = es; v.e_hf = eh; v.e_fin = ef; v.e_rem = er;
        return v;
    endfunction

    // One clock with the given inputs; outputs sampled 1 time unit after the edge
    task automatic step(input logic r, input logic [2:0] s, input logic [1:0] m, input logic t);
        @(negedge cp);
        rst = r; state = s; modeSel = m; tick = t;
        @(posedge cp);
        #1;
    endtask

    task automatic check(input string n, input logic [2:0] ei, input logic [2:0] es,
                         input logic eh, input logic [2:0] ef, input logic [7:0] er);
        checks++;
        if (initTime !== ei || shinning !== es || hadFinish !== eh ||
            finishTime !== ef || remainSec !== er) begin
            errors++;
            $display("FAIL %s: got init=%0d shin=%0d hf=%0d fin=%0d rem=%0d, expected init=%0d shin=%0d hf=%0d fin=%0d rem=%0d",
                     n, initTime, shinning, hadFinish, finishTime, remainSec, ei, es, eh, ef, er);
        end
    endtask

    initial begin
`ifndef WPT_TICK_DIV_EN
        // Each record is one tick period: 3 quiet cycles then tick=tk
        vecs.push_back(mk("reset",        1, 0, 0, 0, 3, 0, 0, 5, 0));
        vecs.push_back(mk("begin_t1",     0, 1, 0, 1, 2, 0, 0, 5, 0));
        vecs.push_back(mk("begin_t2",     0, 1, 0, 1, 1, 0, 0, 5, 0));
        vecs.push_back(mk("begin_t3",     0, 1, 0, 1, 0, 0, 0, 5, 0));
        vecs.push_back(mk("begin_sat",    0, 1, 0, 1, 0, 0, 0, 5, 0));
        vecs.push_back(mk("set_full",     0, 2, 0, 0, 0, 1, 0, 5, 11));
        vecs.push_back(mk("run_t1",       0, 3, 0, 1, 0, 1, 0, 5, 10));
        vecs.push_back(mk("run_t2",       0, 3, 0, 1, 0, 1, 0, 5, 9));
        vecs.push_back(mk("run_t3",       0, 3, 0, 1, 0, 1, 0, 5, 8));
        vecs.push_back(mk("run_t4_spin",  0, 3, 0, 1, 0, 3, 0, 5, 7));
        vecs.push_back(mk("run_t5",       0, 3, 0, 1, 0, 3, 0, 5, 6));
        vecs.push_back(mk("run_t6_rinse", 0, 3, 0, 1, 0, 5, 0, 5, 5));
        vecs.push_back(mk("run_t7",       0, 3, 0, 1, 0, 5, 0, 5, 4));
        vecs.push_back(mk("run_t8",       0, 3, 0, 1, 0, 5, 0, 5, 3));
        vecs.push_back(mk("run_t9_spin2", 0, 3, 0, 1, 0, 7, 0, 5, 2));
        vecs.push_back(mk("run_t10",      0, 3, 0, 1, 0, 7, 0, 5, 1));
        vecs.push_back(mk("run_t11_done", 0, 3, 0, 1, 0, 0, 1, 5, 0));
        vecs.push_back(mk("run_after",    0, 3, 0, 1, 0, 0, 1, 5, 0));
        vecs.push_back(mk("fin_t1",       0, 6, 0, 1, 0, 0, 1, 4, 0));
        vecs.push_back(mk("fin_t2",       0, 6, 0, 1, 0, 0, 1, 3, 0));
        vecs.push_back(mk("fin_t3",       0, 6, 0, 1, 0, 0, 1, 2, 0));
        vecs.push_back(mk("fin_t4",       0, 6, 0, 1, 0, 0, 1, 1, 0));
        vecs.push_back(mk("fin_t5",       0, 6, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("fin_sat",      0, 6, 0, 1, 0, 0, 1, 0, 0));
        vecs.push_back(mk("set_spin",     0, 2, 3, 0, 0, 7, 0, 5, 2));
        vecs.push_back(mk("spin_t1",      0, 3, 3, 1, 0, 7, 0, 5, 1));
        vecs.push_back(mk("spin_t2_done", 0, 3, 3, 1, 0, 0, 1, 5, 0));
        vecs.push_back(mk("fin_again",    0, 6, 3, 1, 0, 0, 1, 4, 0));
        vecs.push_back(mk("set_reload",   0, 2, 0, 0, 0, 1, 0, 5, 11));
        vecs.push_back(mk("run_mode_ign1",0, 3, 3, 1, 0, 1, 0, 5, 10));
        vecs.push_back(mk("run_mode_ign2",0, 3, 3, 1, 0, 1, 0, 5, 9));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("pause_hold", 0, 5, 3, 1, 0, 1, 0, 5, 9));
        vecs.push_back(mk("resume_t1",    0, 3, 3, 1, 0, 1, 0, 5, 8));
        vecs.push_back(mk("resume_t2",    0, 3, 3, 1, 0, 3, 0, 5, 7));
        vecs.push_back(mk("error_hold",   0, 4, 0, 1, 0, 3, 0, 5, 7));
        vecs.push_back(mk("illegal_hold", 0, 7, 0, 1, 0, 3, 0, 5, 7));
        vecs.push_back(mk("resume_t3",    0, 3, 0, 1, 0, 3, 0, 5, 6));
        vecs.push_back(mk("shutdown",     0, 0, 2, 1, 3, 0, 0, 5, 0));

        foreach (vecs[i]) begin
            for (int c = 0; c < 3; c++) step(vecs[i].rst, vecs[i].st, vecs[i].m, 1'b0);
            step(vecs[i].rst, vecs[i].st, vecs[i].m, vecs[i].tk);
            check(vecs[i].name, vecs[i].e_init, vecs[i].e_shin, vecs[i].e_hf,
                  vecs[i].e_fin, vecs[i].e_rem);
        end

        // Tick in the very first cycle of begin acts immediately
        step(0, 3'd1, 2'd0, 1'b1);
        check("begin_first_cycle", 3'd2, 3'd0, 1'b0, 3'd5, 8'd0);

        // Tick in the first run cycle after set
        step(0, 3'd2, 2'd1, 1'b0);
        check("set_wash_spin", 3'd0, 3'd1, 1'b0, 3'd5, 8'd6);
        step(0, 3'd3, 2'd1, 1'b1);
        check("run_first_cycle", 3'd0, 3'd1, 1'b0, 3'd5, 8'd5);
        step(0, 3'd3, 2'd1, 1'b0);
        check("run_no_tick", 3'd0, 3'd1, 1'b0, 3'd5, 8'd5);
        step(0, 3'd3, 2'd1, 1'b1);
        step(0, 3'd3, 2'd1, 1'b1);
        step(0, 3'd3, 2'd1, 1'b1);
        check("wash_spin_skip_to_7", 3'd0, 3'd7, 1'b0, 3'd5, 8'd2);

        // Synchronous reset mid-spin wins over tick
        step(1, 3'd3, 2'd1, 1'b1);
        check("rst_mid_spin", 3'd3, 3'd0, 1'b0, 3'd5, 8'd0);

        // Rinse+spin mode starts at phase 5
        step(0, 3'd2, 2'd2, 1'b0);
        check("set_rinse_spin", 3'd0, 3'd5, 1'b0, 3'd5, 8'd5);
`else
        // Divided tick: tick port held low, divider fires every 4th cycle
        step(1, 3'd0, 2'd0, 1'b0);
        step(1, 3'd0, 2'd0, 1'b0);
        check("div_reset", 3'd3, 3'd0, 1'b0, 3'd5, 8'd0);
        for (int c = 0; c < 3; c++) step(0, 3'd1, 2'd0, 1'b0);
        check("div_before_tick", 3'd3, 3'd0, 1'b0, 3'd5, 8'd0);
        step(0, 3'd1, 2'd0, 1'b0);
        check("div_tick1", 3'd2, 3'd0, 1'b0, 3'd5, 8'd0);
        for (int c = 0; c < 8; c++) step(0, 3'd1, 2'd0, 1'b0);
        check("div_tick3", 3'd0, 3'd0, 1'b0, 3'd5, 8'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
